writeback_unit: RTL and testbench

//  Parametrised WB stage for the 5-stage RISC-V pipeline: MEM/WB register, 5-way result select,

---
 rtl/writeback_unit.sv | 169 ++++++++++++++++
 tb/tb_writeback_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Writeback stage: MEM/WB register, result select with load extraction, and a
// write-port arbiter that slots late multicycle results in behind the pipeline.
module writeback_unit #(
  parameter int XLEN       = 32,
  parameter int RA_W       = 5,
  parameter int LATE_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              Valid_M,
  input  logic                              RegWrite_M,
  input  logic [RA_W-1:0]                   Rd_M,
  input  logic [2:0]                        ResultSrc_M,
  input  logic [2:0]                        Funct3_M,
  input  logic [XLEN-1:0]                   ALU_Result_M,
  input  logic [XLEN-1:0]                   ReadData_M,
  input  logic [XLEN-1:0]                   PCPlus4_M,
  input  logic [XLEN-1:0]                   CSRData_M,
  input  logic [XLEN-1:0]                   ImmExt_M,
  input  logic                              late_valid_i,
  output logic                              late_ready_o,
  input  logic [RA_W-1:0]                   late_rd_i,
  input  logic [XLEN-1:0]                   late_data_i,
  output logic                              RegWrite_W,
  output logic [RA_W-1:0]                   Rd_W,
  output logic [XLEN-1:0]                   Result_W,
  output logic [$clog2(LATE_DEPTH):0]       late_count_o,
  output logic                              bad_src_o
);

  localparam int PTR_W = $clog2(LATE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic            wb_valid;
  logic            wb_regwrite;
  logic [RA_W-1:0] wb_rd;
  logic [2:0]      wb_src;
  logic [2:0]      wb_funct3;
  logic [XLEN-1:0] wb_alu;
  logic [XLEN-1:0] wb_rdata;
  logic [XLEN-1:0] wb_pc4;
  logic [XLEN-1:0] wb_csr;
  logic [XLEN-1:0] wb_imm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_rd       <= '0;
      wb_src      <= '0;
      wb_funct3   <= '0;
      wb_alu      <= '0;
      wb_rdata    <= '0;
      wb_pc4      <= '0;
      wb_csr      <= '0;
      wb_imm      <= '0;
    end else begin
      wb_valid    <= Valid_M;
      wb_regwrite <= Valid_M & RegWrite_M;
      wb_rd       <= Rd_M;
      wb_src      <= ResultSrc_M;
      wb_funct3   <= Funct3_M;
      wb_alu      <= ALU_Result_M;
      wb_rdata    <= ReadData_M;
      wb_pc4      <= PCPlus4_M;
      wb_csr      <= CSRData_M;
      wb_imm      <= ImmExt_M;
    end
  end

  // Halfword lane uses only address bit 1; misaligned halves never reach WB.
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] load_val;
  logic            load_ok;

  assign ld_byte = wb_rdata[{wb_alu[1:0], 3'b000} +: 8];
  assign ld_half = wb_rdata[{wb_alu[1], 4'b0000} +: 16];

  always_comb begin
    load_val = '0;
    load_ok  = 1'b1;
    case (wb_funct3)
      3'b000:  load_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  load_val = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b010:  load_val = wb_rdata;
      3'b100:  load_val = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, ld_half};
      default: load_ok  = 1'b0;
    endcase
  end

  logic [XLEN-1:0] sel_val;
  logic            src_ok;

  always_comb begin
    sel_val = '0;
    src_ok  = 1'b1;
    case (wb_src)
      3'b000: sel_val = wb_alu;
      3'b001: begin
        src_ok  = load_ok;
        sel_val = load_ok ? load_val : '0;
      end
      3'b010: sel_val = wb_pc4;
      3'b011: sel_val = wb_csr;
      3'b100: sel_val = wb_imm;
      default: src_ok = 1'b0;
    endcase
  end

  logic pipe_wr;

  assign bad_src_o = wb_valid & ~src_ok;
  assign pipe_wr   = wb_regwrite & (wb_rd != '0) & src_ok;

  logic [RA_W-1:0] fifo_rd   [LATE_DEPTH];
  logic [XLEN-1:0] fifo_data [LATE_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_push;
  logic             fifo_pop;

  // Readiness looks only at occupancy so a full FIFO cannot refill in the cycle it drains.
  assign late_ready_o = (count < CNT_W'(LATE_DEPTH)) & rst;
  assign fifo_push    = late_valid_i & late_ready_o & (late_rd_i != '0);
  assign fifo_pop     = ~pipe_wr & (count != '0);
  assign late_count_o = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_rd[wr_ptr]   <= late_rd_i;
      fifo_data[wr_ptr] <= late_data_i;
    end
  end

  always_comb begin
    RegWrite_W = 1'b0;
    Rd_W       = '0;
    Result_W   = '0;
    if (pipe_wr) begin
      RegWrite_W = 1'b1;
      Rd_W       = wb_rd;
      Result_W   = sel_val;
    end else if (fifo_pop) begin
      RegWrite_W = 1'b1;
      Rd_W       = fifo_rd[rd_ptr];
      Result_W   = fifo_data[rd_ptr];
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus queues expected regfile writes,
// a negedge monitor pops and compares every write the DUT performs.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        Valid_M, RegWrite_M;
  logic [4:0]  Rd_M;
  logic [2:0]  ResultSrc_M, Funct3_M;
  logic [31:0] ALU_Result_M, ReadData_M, PCPlus4_M, CSRData_M, ImmExt_M;
  logic        late_valid_i, late_ready_o;
  logic [4:0]  late_rd_i;
  logic [31:0] late_data_i;
  logic        RegWrite_W;
  logic [4:0]  Rd_W;
  logic [31:0] Result_W;
  logic [2:0]  late_count_o;
  logic        bad_src_o;

  writeback_unit #(.XLEN(32), .RA_W(5), .LATE_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .Valid_M(Valid_M), .RegWrite_M(RegWrite_M), .Rd_M(Rd_M),
    .ResultSrc_M(ResultSrc_M), .Funct3_M(Funct3_M),
    .ALU_Result_M(ALU_Result_M), .ReadData_M(ReadData_M),
    .PCPlus4_M(PCPlus4_M), .CSRData_M(CSRData_M), .ImmExt_M(ImmExt_M),
    .late_valid_i(late_valid_i), .late_ready_o(late_ready_o),
    .late_rd_i(late_rd_i), .late_data_i(late_data_i),
    .RegWrite_W(RegWrite_W), .Rd_W(Rd_W), .Result_W(Result_W),
    .late_count_o(late_count_o), .bad_src_o(bad_src_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every regfile write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && RegWrite_W === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%08h expected no write at %0t",
                 Rd_W, Result_W, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_rd", {27'd0, Rd_W}, {27'd0, e.rd});
        check("wr_data", Result_W, e.data);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input logic v, input logic rw, input logic [4:0] rd,
                         input logic [2:0] src, input logic [2:0] f3, input logic [31:0] alu);
    Valid_M      = v;
    RegWrite_M   = rw;
    Rd_M         = rd;
    ResultSrc_M  = src;
    Funct3_M     = f3;
    ALU_Result_M = alu;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic bubble();
    drive_m(1'b0, 1'b0, 5'd0, 3'b000, 3'b000, 32'd0);
  endtask

  task automatic late(input logic v, input logic [4:0] rd, input logic [31:0] data);
    late_valid_i = v;
    late_rd_i    = rd;
    late_data_i  = data;
  endtask

  logic [2:0]  ld_f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b101, 3'b000};
  logic [31:0] ld_alu [6] = '{32'h102, 32'h102, 32'h102, 32'h100, 32'h100, 32'h101};
  logic [31:0] ld_exp [6] = '{32'hFFFF_FF81, 32'h0000_0081, 32'hFFFF_8081,
                              32'h8081_F27F, 32'h0000_F27F, 32'hFFFF_FFF2};
  logic [2:0]  sel_src [4] = '{3'b000, 3'b010, 3'b011, 3'b100};
  logic [31:0] sel_exp [4] = '{32'h10, 32'h104, 32'hABCD, 32'h1234_5000};

  initial begin
    rst          = 1'b0;
    ReadData_M   = 32'h8081_F27F;
    PCPlus4_M    = 32'h104;
    CSRData_M    = 32'hABCD;
    ImmExt_M     = 32'h1234_5000;
    bubble();
    late(1'b0, 5'd0, 32'd0);

    #12;
    check("rst_regwrite", {31'd0, RegWrite_W}, 32'd0);
    check("rst_rd", {27'd0, Rd_W}, 32'd0);
    check("rst_result", Result_W, 32'd0);
    check("rst_bad", {31'd0, bad_src_o}, 32'd0);
    check("rst_ready", {31'd0, late_ready_o}, 32'd0);
    check("rst_count", {29'd0, late_count_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    check("ready_after_rst", {31'd0, late_ready_o}, 32'd1);

    // Result select, ALU field carries 0x10
    for (int i = 0; i < 4; i++) begin
      drive_m(1'b1, 1'b1, 5'd5, sel_src[i], 3'b010, 32'h10);
      expect_wr(5'd5, sel_exp[i]);
      cyc();
    end
    drive_m(1'b1, 1'b1, 5'd5, 3'b111, 3'b010, 32'h10);
    cyc();
    check("illegal_src_bad", {31'd0, bad_src_o}, 32'd1);
    check("illegal_src_nowrite", {31'd0, RegWrite_W}, 32'd0);
    check("illegal_src_result", Result_W, 32'd0);
    bubble();
    cyc();
    check("bubble_bad", {31'd0, bad_src_o}, 32'd0);
    check("idle_rd", {27'd0, Rd_W}, 32'd0);

    // Load extraction
    for (int i = 0; i < 6; i++) begin
      drive_m(1'b1, 1'b1, 5'd9, 3'b001, ld_f3[i], ld_alu[i]);
      expect_wr(5'd9, ld_exp[i]);
      cyc();
    end
    drive_m(1'b1, 1'b1, 5'd9, 3'b001, 3'b011, 32'h100);
    cyc();
    check("illegal_f3_bad", {31'd0, bad_src_o}, 32'd1);
    check("illegal_f3_nowrite", {31'd0, RegWrite_W}, 32'd0);
    bubble();
    cyc();

    // Arbitration: late result held while pipeline writes every cycle
    late(1'b1, 5'd7, 32'hDEAD);
    for (int i = 0; i < 3; i++) begin
      drive_m(1'b1, 1'b1, 5'd3, 3'b000, 3'b000, 32'h33);
      expect_wr(5'd3, 32'h33);
      cyc();
      late(1'b0, 5'd0, 32'd0);
      check("arb_held_count", {29'd0, late_count_o}, 32'd1);
    end
    bubble();
    expect_wr(5'd7, 32'hDEAD);
    cyc();
    check("arb_late_wr", {31'd0, RegWrite_W}, 32'd1);
    cyc();
    check("arb_drained", {29'd0, late_count_o}, 32'd0);

    // Fill to full, drain two, refill across the pointer wrap
    for (int i = 0; i < 4; i++) begin
      drive_m(1'b1, 1'b1, 5'd3, 3'b000, 3'b000, 32'h44);
      expect_wr(5'd3, 32'h44);
      late(1'b1, 5'(10 + i), 32'h110 + i);
      cyc();
    end
    late(1'b1, 5'd14, 32'h114);
    check("full_count", {29'd0, late_count_o}, 32'd4);
    check("full_ready", {31'd0, late_ready_o}, 32'd0);
    drive_m(1'b1, 1'b1, 5'd3, 3'b000, 3'b000, 32'h44);
    expect_wr(5'd3, 32'h44);
    cyc();
    check("full_no_accept", {29'd0, late_count_o}, 32'd4);
    late(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      bubble();
      expect_wr(5'(10 + i), 32'h110 + i);
      cyc();
    end
    drive_m(1'b1, 1'b1, 5'd3, 3'b000, 3'b000, 32'h44);
    expect_wr(5'd3, 32'h44);
    late(1'b1, 5'd14, 32'h114);
    cyc();
    check("pushpop_count", {29'd0, late_count_o}, 32'd3);
    expect_wr(5'd3, 32'h44);
    late(1'b1, 5'd15, 32'h115);
    cyc();
    check("refull_count", {29'd0, late_count_o}, 32'd4);
    late(1'b1, 5'd16, 32'h116);
    check("refull_ready", {31'd0, late_ready_o}, 32'd0);
    late(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      bubble();
      expect_wr(5'(12 + i), 32'h112 + i);
      cyc();
    end
    cyc();
    check("wrap_drained", {29'd0, late_count_o}, 32'd0);

    // Rd=0 on both paths
    drive_m(1'b1, 1'b1, 5'd0, 3'b000, 3'b000, 32'h55);
    late(1'b1, 5'd0, 32'hBEEF);
    check("rd0_ready", {31'd0, late_ready_o}, 32'd1);
    cyc();
    late(1'b0, 5'd0, 32'd0);
    check("rd0_nowrite", {31'd0, RegWrite_W}, 32'd0);
    check("rd0_count", {29'd0, late_count_o}, 32'd0);
    bubble();
    cyc();
    check("rd0_still_nowrite", {31'd0, RegWrite_W}, 32'd0);

    // Reset mid-run with three queued late results
    for (int i = 0; i < 3; i++) begin
      drive_m(1'b1, 1'b1, 5'd3, 3'b000, 3'b000, 32'h66);
      expect_wr(5'd3, 32'h66);
      late(1'b1, 5'(20 + i), 32'h220 + i);
      cyc();
    end
    late(1'b0, 5'd0, 32'd0);
    check("pre_rst_count", {29'd0, late_count_o}, 32'd3);
    @(negedge clk);
    #1;
    rst = 1'b0;
    bubble();
    #1;
    check("mid_rst_regwrite", {31'd0, RegWrite_W}, 32'd0);
    check("mid_rst_rd", {27'd0, Rd_W}, 32'd0);
    check("mid_rst_result", Result_W, 32'd0);
    check("mid_rst_ready", {31'd0, late_ready_o}, 32'd0);
    check("mid_rst_count", {29'd0, late_count_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    check("post_rst_ready", {31'd0, late_ready_o}, 32'd1);
    for (int i = 0; i < 3; i++) cyc();
    check("post_rst_count", {29'd0, late_count_o}, 32'd0);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL outstanding_writes: got %0d pending expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
